// File: rtl/cpu_stream_pkg.sv
// Shared types and sizing helpers for the CPU result streamer.
// Build option: CPU_STREAM_PARITY_EN adds a registered even-parity pin.
package cpu_stream_pkg;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } state_e;

  function automatic int beats(int data_w, int pins_w);
    return data_w / pins_w;
  endfunction

  function automatic int idx_w(int data_w, int pins_w);
    int n;
    n = beats(data_w, pins_w);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Single-clock FIFO buffering whole result words ahead of the serialiser.
// Full/empty come from the registered occupancy count only.
module stream_sync_fifo
  import cpu_stream_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cpu_result_streamer.sv
// Buffers core result words and serialises them onto PINS_W pins, LS beat first.
// Build option: CPU_STREAM_PARITY_EN registers ^pin_data onto pin_parity.
module cpu_result_streamer
  import cpu_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PINS_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ack_mode,
  input  logic              pin_ack,
  output logic [PINS_W-1:0] pin_data,
  output logic              pin_valid,
  output logic              pin_first,
  output logic              pin_parity
);

  localparam int BEATS = beats(DATA_W, PINS_W);
  localparam int IW    = idx_w(DATA_W, PINS_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PINS_W-1:0] pin_data_q, pin_data_d;
  logic              pin_valid_q, pin_valid_d;
  logic              pin_first_q, pin_first_d;
  logic              ack_s1_q, ack_s2_q, ack_s3_q;
  logic              ack_rise, advance;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] word_shr;

  stream_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign ack_rise = ack_s2_q & ~ack_s3_q;
  assign advance  = ack_mode ? ack_rise : 1'b1;
  assign word_shr = word_q >> PINS_W;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    pin_data_d  = pin_data_q;
    pin_valid_d = pin_valid_q;
    pin_first_d = pin_first_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          word_d      = fifo_data;
          idx_d       = '0;
          pin_data_d  = fifo_data[PINS_W-1:0];
          pin_valid_d = 1'b1;
          pin_first_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (advance) begin
          if (idx_q != IW'(BEATS-1)) begin
            word_d      = word_shr;
            idx_d       = idx_q + 1'b1;
            pin_data_d  = word_shr[PINS_W-1:0];
            pin_first_d = 1'b0;
          end else if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            word_d      = fifo_data;
            idx_d       = '0;
            pin_data_d  = fifo_data[PINS_W-1:0];
            pin_first_d = 1'b1;
          end else begin
            // pin_data keeps the last beat for static displays
            pin_valid_d = 1'b0;
            pin_first_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      pin_data_q  <= '0;
      pin_valid_q <= 1'b0;
      pin_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      pin_data_q  <= pin_data_d;
      pin_valid_q <= pin_valid_d;
      pin_first_q <= pin_first_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      ack_s3_q <= 1'b0;
    end else begin
      ack_s1_q <= pin_ack;
      ack_s2_q <= ack_s1_q;
      ack_s3_q <= ack_s2_q;
    end
  end

`ifdef CPU_STREAM_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = ^pin_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign pin_parity = parity_q;
`else
  assign pin_parity = 1'b0;
`endif

  assign pin_data  = pin_data_q;
  assign pin_valid = pin_valid_q;
  assign pin_first = pin_first_q;

endmodule

// File: tb/tb_cpu_result_streamer.sv
// Directed and randomized checks of cpu_result_streamer against a beat-queue model.
// Covers free/ack pacing, backpressure, async reset and the single-beat build.
module tb_cpu_result_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        ack_mode = 1'b0;
  logic        pin_ack = 1'b0;
  logic [15:0] pin_data;
  logic        pin_valid;
  logic        pin_first;
  logic        pin_parity;

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [15:0] in_data1 = '0;
  logic [15:0] pin_data1;
  logic        pin_valid1;
  logic        pin_first1;
  logic        pin_parity1;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_d [$];
  logic        exp_f [$];

  always #5 clk = ~clk;

  cpu_result_streamer #(.DATA_W(32), .PINS_W(16), .DEPTH(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ack_mode   (ack_mode),
    .pin_ack    (pin_ack),
    .pin_data   (pin_data),
    .pin_valid  (pin_valid),
    .pin_first  (pin_first),
    .pin_parity (pin_parity)
  );

  cpu_result_streamer #(.DATA_W(16), .PINS_W(16), .DEPTH(2)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .in_data    (in_data1),
    .ack_mode   (1'b0),
    .pin_ack    (1'b0),
    .pin_data   (pin_data1),
    .pin_valid  (pin_valid1),
    .pin_first  (pin_first1),
    .pin_parity (pin_parity1)
  );

  function automatic logic par(input logic [15:0] b);
`ifdef CPU_STREAM_PARITY_EN
    return ^b;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] d,
                          input logic f);
    chk({tag, "_valid"}, 32'(pin_valid), 32'd1);
    chk({tag, "_data"}, 32'(pin_data), 32'(d));
    chk({tag, "_first"}, 32'(pin_first), 32'(f));
    chk({tag, "_par"}, 32'(pin_parity), 32'(par(d)));
  endtask

  task automatic add_word(input logic [31:0] w);
    exp_d.push_back(w[15:0]);
    exp_f.push_back(1'b1);
    exp_d.push_back(w[31:16]);
    exp_f.push_back(1'b0);
  endtask

  task automatic pulse();
    pin_ack = 1'b1;
    tick();
    pin_ack = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    pin_ack = 1'b0;
    exp_d.delete();
    exp_f.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int acc;
    logic a;
    logic [31:0] w;

    // reset state
    #3;
    chk("rst_data", 32'(pin_data), 32'd0);
    chk("rst_valid", 32'(pin_valid), 32'd0);
    chk("rst_first", 32'(pin_first), 32'd0);
    chk("rst_par", 32'(pin_parity), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // free mode single word
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    tick();
    chk_beat("one_b0", 16'hBEEF, 1'b1);
    tick();
    chk_beat("one_b1", 16'hDEAD, 1'b0);
    tick();
    chk("one_idle_valid", 32'(pin_valid), 32'd0);
    chk("one_idle_hold", 32'(pin_data), 32'h0000DEAD);
    chk("one_idle_first", 32'(pin_first), 32'd0);

    // free mode back-to-back words, no bubble
    in_valid = 1'b1;
    in_data = 32'h11112222;
    tick();
    in_data = 32'h33334444;
    tick();
    in_valid = 1'b0;
    chk_beat("b2b_0", 16'h2222, 1'b1);
    tick();
    chk_beat("b2b_1", 16'h1111, 1'b0);
    tick();
    chk_beat("b2b_2", 16'h4444, 1'b1);
    tick();
    chk_beat("b2b_3", 16'h3333, 1'b0);
    tick();
    chk("b2b_end", 32'(pin_valid), 32'd0);

    // randomized free-mode traffic vs beat queue
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 99) < 55);
      in_data = $urandom;
      a = in_valid && in_ready;
      w = in_data;
      tick();
      if (a) add_word(w);
      if (pin_valid) begin
        if (exp_d.size() == 0) begin
          chk("rnd_unexpected", 32'(pin_valid), 32'd0);
        end else begin
          chk_beat("rnd", exp_d.pop_front(), exp_f.pop_front());
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 60 && exp_d.size() > 0; i++) begin
      tick();
      if (pin_valid) chk_beat("drain", exp_d.pop_front(), exp_f.pop_front());
    end
    chk("drain_left", 32'(exp_d.size()), 32'd0);
    tick();
    chk("drain_idle", 32'(pin_valid), 32'd0);

    // ack mode, no acks: backpressure after 5 words
    ack_mode = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      a = in_ready;
      w = in_data;
      tick();
      if (a) begin
        acc++;
        add_word(w);
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk_beat("bp_b0", exp_d.pop_front(), exp_f.pop_front());
    pulse();
    chk_beat("bp_b1", exp_d.pop_front(), exp_f.pop_front());
    chk("bp_ready_mid", 32'(in_ready), 32'd0);
    pulse();
    chk("bp_ready_free", 32'(in_ready), 32'd1);
    while (exp_d.size() > 0) begin
      chk_beat("ackq", exp_d.pop_front(), exp_f.pop_front());
      pulse();
    end
    chk("ackq_idle", 32'(pin_valid), 32'd0);

    // ack rise while idle is not remembered
    pulse();
    in_valid = 1'b1;
    in_data = 32'hCAFEF00D;
    tick();
    in_valid = 1'b0;
    tick();
    chk_beat("held_b0", 16'hF00D, 1'b1);

    // ack held high: one advance, visible after A+3
    pin_ack = 1'b1;
    tick();
    chk_beat("held_a1", 16'hF00D, 1'b1);
    tick();
    chk_beat("held_a2", 16'hF00D, 1'b1);
    tick();
    chk_beat("held_a3", 16'hCAFE, 1'b0);
    repeat (7) tick();
    chk_beat("held_a10", 16'hCAFE, 1'b0);
    pin_ack = 1'b0;
    repeat (4) tick();
    chk_beat("held_low", 16'hCAFE, 1'b0);
    pin_ack = 1'b1;
    repeat (4) tick();
    pin_ack = 1'b0;
    chk("held_idle", 32'(pin_valid), 32'd0);
    chk("held_hold", 32'(pin_data), 32'h0000CAFE);
    repeat (4) tick();

    // async reset mid-word with two words queued
    acc = 0;
    for (int i = 0; i < 10 && acc < 3; i++) begin
      in_valid = 1'b1;
      in_data = 32'hA5A50000 | 32'(i);
      a = in_ready;
      tick();
      if (a) acc++;
    end
    in_valid = 1'b0;
    chk("mid_valid", 32'(pin_valid), 32'd1);
    chk("mid_first", 32'(pin_first), 32'd1);
    chk("mid_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(pin_data), 32'd0);
    chk("arst_valid", 32'(pin_valid), 32'd0);
    chk("arst_first", 32'(pin_first), 32'd0);
    chk("arst_par", 32'(pin_parity), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_valid", 32'(pin_valid), 32'd0);
    end

    // single-beat build: every beat is a first beat
    in_valid1 = 1'b1;
    in_data1 = 16'h0007;
    tick();
    in_data1 = 16'h0003;
    tick();
    in_valid1 = 1'b0;
    chk("sb0_valid", 32'(pin_valid1), 32'd1);
    chk("sb0_data", 32'(pin_data1), 32'h0007);
    chk("sb0_first", 32'(pin_first1), 32'd1);
    chk("sb0_par", 32'(pin_parity1), 32'(par(16'h0007)));
    tick();
    chk("sb1_valid", 32'(pin_valid1), 32'd1);
    chk("sb1_data", 32'(pin_data1), 32'h0003);
    chk("sb1_first", 32'(pin_first1), 32'd1);
    chk("sb1_par", 32'(pin_parity1), 32'(par(16'h0003)));
    tick();
    chk("sb_idle", 32'(pin_valid1), 32'd0);
    chk("sb_hold", 32'(pin_data1), 32'h0003);

    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
